sbox_share_ctrl: RTL
====================

# sbox_share_ctrl

Controller that time-shares a bank of byte S-box lookups between two requesters: the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). It arbitrates, slices the operand into byte chunks, sequences chunks through the lane bank and assembles the substituted result. It sits between the round controller / key scheduler and the S-box lanes.

## Interface
- LANES, 4, S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- st_req  in  1  state job request; held high until st_done.
- st_data  in  128  state operand; byte i = bits [8i+7:8i].
- st_gnt  out  1  high for the whole state job, from grant through its done cycle.
- st_done  out  1  one-cycle pulse; st_result valid.
- st_result  out  128  substituted state; held until the next state job completes.
- kw_req  in  1  key-word job request; held high until kw_done.
- kw_data  in  32  key word operand, same byte order.
- kw_gnt  out  1  high for the whole key job, from grant through its done cycle.
- kw_done  out  1  one-cycle pulse; kw_result valid.
- kw_result  out  32  substituted word; held until the next key job completes.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN_ST, RUN_KW, DONE.
- IDLE: if any request is high, grant one job, capture its operand into the operand register, clear chunk counter, go to RUN_ST or RUN_KW. Operand may change after the grant cycle.
- Arbitration when both requests are high in IDLE: kw wins (fixed priority; see Configuration). No preemption: a running job always completes.
- RUN_x: each cycle feeds chunk c (bytes c*LANES .. c*LANES+LANES-1) to the lanes and writes the lane outputs into those byte slots of the result register. Counter increments; after the last chunk go to DONE.
- Chunk count: K_ST = 16/LANES; K_KW = max(1, 4/LANES). For LANES > 4, key job lanes 4..LANES-1 are fed 8'h00 and their outputs discarded.
- DONE: assert the matching done pulse, then return to IDLE. Requests are not sampled in DONE.
- Only the granted requester's result register is written; the other holds its value.

## Timing
- Reset (async, rst_n low): state IDLE, counter 0, all outputs 0 (st_gnt, kw_gnt, st_done, kw_done, busy, st_result, kw_result).
- Request high in IDLE at cycle T: gnt and busy high from T+1. Chunks are processed T+1..T+K. done is high at T+K+1, and gnt and busy fall at T+K+2.
- LANES=4: state latency 5 cycles request-to-done, key latency 2 cycles.
- Requester drops req in the cycle after done. A req still high when the FSM is in IDLE is a new job.
- Back-to-back: a losing requester is granted in the IDLE cycle following the winner's DONE, with 1 idle cycle between jobs.
- Reset asserted mid-job: job aborted, no done pulse. Requester must re-request.

## Configuration
- SBOX_SHARE_RR_EN defined: round-robin arbitration. On a simultaneous request in IDLE, grant the requester not served last. The last-served flag is reset to "st" so kw wins first.
- Undefined: fixed priority, kw always wins on a tie.
- A single request is granted immediately in both builds.

## Structure
- Package sbox_share_pkg holds: state enum, LANES legality check constant, K_ST/K_KW derivation functions, byte-slice helper.
- One sub-module: sbox_lane_bank, with LANES parallel combinational byte S-box lookups (8-bit in, 8-bit out each). This controller holds all registers.

## Test plan
- SubBytes, LANES=4: st_data bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 (byte0 first) -> st_done at T+5, st_result bytes d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- SubWord: kw_data bytes cf 4f 3c 09 -> kw_done at T+2, kw_result bytes 8a 84 eb 01.
- Simultaneous st_req and kw_req:
  - fixed priority: kw done first, st granted after 1 idle cycle.
  - SBOX_SHARE_RR_EN, two repeated ties: kw served first, then st, on each tie.
- rst_n low at T+2 of a state job -> all outputs 0 immediately, no st_done. A new request after reset completes normally.
- Sweep LANES=1,2,8,16 with all-00 state (result all 63) and all-ff state (result all 16). Check latency 16/LANES+1 each time.
- Change st_data right after grant -> result reflects the operand captured at grant.

Source files
------------

// File: rtl/sbox_share_pkg.sv
// sbox_share_pkg: FSM state type and elaboration-time helpers shared by the
// S-box sharing controller and its lane bank.
package sbox_share_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        RUN_KW = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic bit lanes_legal(input int lanes);
        return lanes inside {1, 2, 4, 8, 16};
    endfunction

    // Chunks needed to push a 16-byte state through the lane bank.
    function automatic int k_st(input int lanes);
        return 16 / lanes;
    endfunction

    // A key word is 4 bytes; wide banks still need one chunk.
    function automatic int k_kw(input int lanes);
        return (lanes >= 4) ? 1 : 4 / lanes;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] v, input int idx);
        return v[8*idx +: 8];
    endfunction

endpackage

// File: rtl/sbox_lane_bank.sv
// sbox_lane_bank: LANES parallel combinational AES forward S-box lookups,
// byte l of lanes_i maps to byte l of lanes_o.
module sbox_lane_bank
    import sbox_share_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] lanes_i,
    output logic [8*LANES-1:0] lanes_o
);

    // Rows listed in natural order, so entry 0 occupies the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[8*(255 - int'(x)) +: 8];
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lanes_o[8*l +: 8] = sbox(lanes_i[8*l +: 8]);
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-shares a bank of LANES S-box lookups between SubBytes
// (128-bit state) and SubWord (32-bit key word) jobs. Define SBOX_SHARE_RR_EN for
// round-robin tie-breaking; otherwise the key job always wins a tie.
module sbox_share_ctrl
    import sbox_share_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_req,
    input  logic [31:0]  kw_data,
    output logic         kw_gnt,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);

    localparam bit            LANES_OK = lanes_legal(LANES);
    localparam int            K_ST     = k_st(LANES);
    localparam int            K_KW     = k_kw(LANES);
    localparam int            CW       = (K_ST > 1) ? $clog2(K_ST) : 1;
    localparam logic [CW-1:0] LAST_ST  = CW'(K_ST - 1);
    localparam logic [CW-1:0] LAST_KW  = CW'(K_KW - 1);

    if (!LANES_OK) begin : g_lanes_check
        $error("sbox_share_ctrl: LANES must be 1, 2, 4, 8 or 16");
    end

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [127:0]         op_q;
    logic [127:0]         op_merged;
    logic [127:0]         st_result_q;
    logic [31:0]          kw_result_q;
    logic                 st_gnt_q, kw_gnt_q, st_done_q, kw_done_q, busy_q;
    logic [8*LANES-1:0]   lane_in, lane_out;
    logic                 pick_kw;

`ifdef SBOX_SHARE_RR_EN
    logic last_kw_q;
    assign pick_kw = kw_req && (!st_req || !last_kw_q);
`else
    assign pick_kw = kw_req;
`endif

    // Lanes beyond the key word's 4 bytes see 8'h00 and their outputs are dropped.
    always_comb begin
        int idx;
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        lane_in = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(cnt_q) * LANES + l;
            if (idx < 16 && (state_q == RUN_ST || (state_q == RUN_KW && idx < 4)))
                lane_in[8*l +: 8] = get_byte(op_q, idx);
        end
    end

    // Substituted bytes are written back in place, so op_q doubles as the accumulator.
    always_comb begin
        int idx;
        op_merged = op_q;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(cnt_q) * LANES + l;
            if (idx < 16 && (state_q == RUN_ST || (state_q == RUN_KW && idx < 4)))
                op_merged[8*idx +: 8] = lane_out[8*l +: 8];
        end
    end

    sbox_lane_bank #(.LANES(LANES)) u_lanes (
        .lanes_i (lane_in),
        .lanes_o (lane_out)
    );

    // NOTE: sequential state uses <= only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            st_result_q <= '0;
            kw_result_q <= '0;
            st_gnt_q    <= 1'b0;
            kw_gnt_q    <= 1'b0;
            st_done_q   <= 1'b0;
            kw_done_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SBOX_SHARE_RR_EN
            last_kw_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (st_req || kw_req) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (pick_kw) begin
                            state_q  <= RUN_KW;
                            kw_gnt_q <= 1'b1;
                            op_q     <= {96'h0, kw_data};
                        end else begin
                            state_q  <= RUN_ST;
                            st_gnt_q <= 1'b1;
                            op_q     <= st_data;
                        end
`ifdef SBOX_SHARE_RR_EN
                        last_kw_q <= pick_kw;
`endif
                    end
                end
                RUN_ST: begin
                    op_q  <= op_merged;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ST) begin
                        st_result_q <= op_merged;
                        st_done_q   <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                RUN_KW: begin
                    op_q  <= op_merged;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_KW) begin
                        kw_result_q <= op_merged[31:0];
                        kw_done_q   <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    st_done_q <= 1'b0;
                    kw_done_q <= 1'b0;
                    st_gnt_q  <= 1'b0;
                    kw_gnt_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign st_gnt    = st_gnt_q;
    assign kw_gnt    = kw_gnt_q;
    assign st_done   = st_done_q;
    assign kw_done   = kw_done_q;
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;
    assign busy      = busy_q;

endmodule
